// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic valid/ready pipeline stage carrying LANES x DBITS
// payload plus a PBITS sideband, with flush and a saturating stall counter.
// Build option: define PIPE_STAGE_SKID_EN for the two-entry skid buffer with
// registered in_ready; leave it undefined for a single-entry stage whose
// in_ready is combinational from out_ready.
module pipe_stage_reg #(
  parameter int DBITS = 32,
  parameter int LANES = 3,
  parameter int PBITS = 2,
  parameter int CNTW  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*DBITS-1:0] in_data,
  input  logic [PBITS-1:0]       in_pred,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*DBITS-1:0] out_data,
  output logic [PBITS-1:0]       out_pred,
  input  logic                   flush,
  output logic [1:0]             occupancy,
  output logic [CNTW-1:0]        stall_cnt
);

  localparam int PW = LANES*DBITS + PBITS;

  // Occupancy-encoded control state; the valid flags are decoded from it.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_main;
  logic [CNTW-1:0] r_stall;

  logic            w_main_valid;
  logic            w_skid_valid;
  logic            w_accept;
  logic            w_drain;
  logic [PW-1:0]   w_in;

  assign w_in         = {in_data, in_pred};
  assign w_main_valid = (r_state != ST_EMPTY);
  assign w_accept     = in_valid && in_ready;
  assign w_drain      = w_main_valid && out_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic [PW-1:0] r_skid;

  assign w_skid_valid = (r_state == ST_TWO);
  // Registered back-pressure: ready depends only on the skid flag.
  assign in_ready     = !w_skid_valid;
`else
  assign w_skid_valid = 1'b0;
  // Single entry: a held beat can be replaced only in the cycle it drains.
  assign in_ready     = !w_main_valid || out_ready;
`endif

  assign out_valid = w_main_valid;
  assign out_data  = r_main[PW-1:PBITS];
  assign out_pred  = r_main[PBITS-1:0];
  assign occupancy = {1'b0, w_main_valid} + {1'b0, w_skid_valid};
  assign stall_cnt = r_stall;

  // Handshake FSM: flush wins, then accept/drain moves beats main <- skid <- in.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: all sequential state uses non-blocking assignments so every
    // register in this block samples the pre-edge values of the others.
    if (!reset) begin
      r_state <= ST_EMPTY;
      // NOTE: the payload registers are reset on purpose: out_data/out_pred
      // must read zero after reset, not whatever the flops powered up with.
      r_main  <= '0;
`ifdef PIPE_STAGE_SKID_EN
      r_skid  <= '0;
`endif
    end else if (flush) begin
      // Payload may stay stale; only the valid flags are cleared.
      r_state <= ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_state <= ST_ONE;
            r_main  <= w_in;
          end
        end
        ST_ONE: begin
          if (w_accept && w_drain) begin
            r_main <= w_in;
`ifdef PIPE_STAGE_SKID_EN
          end else if (w_accept) begin
            r_state <= ST_TWO;
            r_skid  <= w_in;
`endif
          end else if (w_drain) begin
            r_state <= ST_EMPTY;
          end
        end
`ifdef PIPE_STAGE_SKID_EN
        ST_TWO: begin
          if (w_drain) begin
            r_state <= ST_ONE;
            r_main  <= r_skid;
          end
        end
`endif
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

  // Saturating count of cycles where the held beat is refused downstream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall <= '0;
    end else if (out_valid && !out_ready && (r_stall != {CNTW{1'b1}})) begin
      r_stall <= r_stall + CNTW'(1);
    end
  end

endmodule
